booth_sequential_multiplier: RTL and testbench



---
 rtl/booth_sequential_multiplier_pkg.sv | 29 ++
 rtl/booth_sequential_multiplier_adder.sv | 40 ++++
 rtl/booth_sequential_multiplier.sv | 135 +++++++++++++
 tb/tb_booth_sequential_multiplier.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_sequential_multiplier_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_sequential_multiplier_pkg;

    // Controller states; the encodings are fixed so that debug dumps read consistently.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Action taken on the accumulator in one Booth step.
    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_t;

    // Radix-2 Booth recoding of the bit pair {Q[0], q_m1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        booth_op_t op;
        case ({q0, q_m1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_sequential_multiplier_adder.sv
// Ripple-carry adder built from the single-bit full-adder cell.

// One-bit full adder cell.
module single_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// N-bit ripple chain; subtraction is done by the caller feeding ~b and cin=1.
module ripple_carry_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar g = 0; g < N; g++) begin : g_bit
        single_bit_full_adder u_fa (
            .a    (a[g]),
            .b    (b[g]),
            .cin  (w_carry[g]),
            .sum  (sum[g]),
            .cout (w_carry[g+1])
        );
    end

    assign cout = w_carry[N];
endmodule

// File: rtl/booth_sequential_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH steps per product.
module booth_sequential_multiplier
    import booth_sequential_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH:0]       r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q_m1;
    logic [WIDTH:0]       r_m;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    booth_op_t            w_op;
    logic                 w_sub;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic                 w_cout_unused;
    logic [WIDTH:0]       w_a_step;
    logic [WIDTH:0]       w_a_shift;
    logic [WIDTH-1:0]     w_q_shift;
    logic                 w_last;

    // A is WIDTH+1 bits wide so that subtracting the most negative M cannot overflow.
    assign w_op     = booth_decode(r_q[0], r_q_m1);
    assign w_sub    = (w_op == BOOTH_SUB);
    assign w_addend = w_sub ? ~r_m : r_m;

    ripple_carry_adder #(
        .N (WIDTH + 1)
    ) u_adder (
        .a    (r_a),
        .b    (w_addend),
        .cin  (w_sub),
        .sum  (w_sum),
        .cout (w_cout_unused)
    );

    assign w_a_step  = (w_op == BOOTH_NOP) ? r_a : w_sum;
    assign w_a_shift = {w_a_step[WIDTH], w_a_step[WIDTH:1]};
    assign w_q_shift = {w_a_step[0], r_q[WIDTH-1:1]};
    assign w_last    = (r_count == CW'(1'b1));

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus registered busy/done flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // Datapath: operand load, Booth add/sub plus arithmetic shift, and product latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= '0;
                        r_q     <= multiplier;
                        r_q_m1  <= 1'b0;
                        r_m     <= {multiplicand[WIDTH-1], multiplicand};
                        r_count <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_shift;
                    r_q     <= w_q_shift;
                    r_q_m1  <= r_q[0];
                    r_count <= r_count - CW'(1'b1);
                    if (w_last) begin
                        r_product <= {w_a_shift[WIDTH-1:0], w_q_shift};
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Self-checking bench for booth_sequential_multiplier (WIDTH=8).
module tb_booth_sequential_multiplier;
    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     mc;
    logic [W-1:0]     mp;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    booth_sequential_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a cycle count since acceptance plus the arithmetic product.
    int                  m_cnt  = 0;
    logic                m_busy = 1'b0;
    logic                m_done = 1'b0;
    logic [2*W-1:0]      m_prod = '0;
    logic signed [2*W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  <= W + 1;
                m_pend <= $signed(mc) * $signed(mp);
            end
            m_busy <= start;
            m_done <= 1'b0;
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 2);
            m_busy <= (m_cnt != 1);
            if (m_cnt == 2) m_prod <= m_pend;
        end
    end

    task automatic check16(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check1("model_busy", busy, m_busy);
            check1("model_done", done, m_done);
            check16("model_product", product, m_prod);
        end
    end

    // Wait for done after an accepting edge; checks latency and the literal product.
    task automatic wait_done(input logic [2*W-1:0] exp, input string name);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end else begin
            tests++;
            if (n != W + 1) begin
                fails++;
                $display("FAIL %s_latency: got %0d expected %0d", name, n, W + 1);
            end
            check16(name, product, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        start = 1'b1;
        mc    = a;
        mp    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mc    = $urandom;
        mp    = $urandom;
        wait_done(exp, name);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic signed [2*W-1:0] rexp;

        rst   = 1'b1;
        start = 1'b0;
        mc    = '0;
        mp    = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check16("reset_product", product, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with hand-computed products.
        run_op(8'd3,   8'd5,   16'h000F, "p_3x5");
        run_op(8'hFD,  8'd5,   16'hFFF1, "p_m3x5");
        run_op(8'd5,   8'hFD,  16'hFFF1, "p_5xm3");
        run_op(8'd0,   8'hB3,  16'h0000, "p_0xm77");
        run_op(8'hB3,  8'd0,   16'h0000, "p_m77x0");
        run_op(8'h80,  8'h80,  16'h4000, "p_m128xm128");
        run_op(8'h7F,  8'h80,  16'hC080, "p_127xm128");
        run_op(8'h80,  8'h7F,  16'hC080, "p_m128x127");
        run_op(8'hFF,  8'hFF,  16'h0001, "p_m1xm1");

        // start held high with changing operands: only the first pair counts.
        start = 1'b1;
        mc    = 8'd12;
        mp    = 8'hF9;
        @(posedge clk);
        #1;
        begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                mc = $urandom;
                mp = $urandom;
                if (done) got = 1'b1;
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL hold_start_timeout: got no done expected done");
            end else if (n != W + 1) begin
                fails++;
                $display("FAIL hold_start_latency: got %0d expected %0d", n, W + 1);
            end
            check16("hold_start_first", product, 16'hFFAC);
        end
        mc = 8'd7;
        mp = 8'd6;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(16'h002A, "hold_start_next");

        // Reset in the middle of RUN abandons the operation.
        start = 1'b1;
        mc    = 8'd100;
        mp    = 8'hFD;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_done", done, 1'b0);
        check16("midrst_product", product, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check1("midrst_no_done", done, 1'b0);
        end
        @(posedge clk);
        #1;
        run_op(8'hF6, 8'd10, 16'hFF9C, "p_after_reset");

        // Random sweep against plain signed arithmetic.
        for (int i = 0; i < 300; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rexp = $signed(ra) * $signed(rb);
            run_op(ra, rb, rexp, "p_random");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
